// File: rtl/alu_sequencer.sv
// alu_sequencer: Mini SRC fetch/decode/execute control sequencer for register-register ALU ops.
// Define ALU_SEQ_MULDIV_EN to add mul/div support with a T6 (HI) writeback state.
module alu_sequencer #(
  parameter int NUM_REGS = 16,
  parameter int IR_W = 32,
  parameter int OP_W = 5,
  parameter int RIDX_W = 4
) (
  input  logic w_clock,
  input  logic w_clear,
  input  logic run,
  input  logic w_mem_ready,
  input  logic [IR_W-1:0] ir_in,
  output logic s_PC, e_MAR, w_IncPC, e_PC,
  output logic w_read, e_MDR, s_MDR, e_IR,
  output logic e_Y, e_alu, e_Z, s_Zlow, s_Zhigh, e_LO, e_HI,
  output logic [OP_W-1:0] alu_opcode,
  output logic [NUM_REGS-1:0] s_R,
  output logic [NUM_REGS-1:0] e_R,
  output logic busy,
  output logic done,
  output logic illegal,
  output logic [3:0] state
);
  localparam logic [3:0] IDLE = 4'd0, T0 = 4'd1, T1 = 4'd2, T2 = 4'd3, T3 = 4'd4;
  localparam logic [3:0] T4 = 4'd5, T5 = 4'd6, T6 = 4'd7, FAULT = 4'd8;
  localparam logic [NUM_REGS-1:0] ONE = NUM_REGS'(1);
  logic [OP_W-1:0] op;
  logic [RIDX_W-1:0] ra, rb, rc;
  logic [3:0] nxt;
  logic t1_first, unary, muldiv, bad_op, bad_idx, bad, retire, t3_drive;
  logic unused;
  assign unused = ^ir_in[IR_W-OP_W-3*RIDX_W-1:0];
  assign unary = op == OP_W'(4) || op == OP_W'(12);
`ifdef ALU_SEQ_MULDIV_EN
  assign muldiv = op == OP_W'(5) || op == OP_W'(6);
  assign bad_op = op > OP_W'(12);
`else
  assign muldiv = 1'b0;
  assign bad_op = op > OP_W'(12) || op == OP_W'(5) || op == OP_W'(6);
`endif
  // mul/div never writes Ra and unary ops never read Rc, so those fields are don't-care there
  assign bad_idx = (!muldiv && 32'(ra) >= NUM_REGS) || 32'(rb) >= NUM_REGS ||
                   (!unary && 32'(rc) >= NUM_REGS);
  assign bad = bad_op || bad_idx;
  assign retire = (state == T5 && !muldiv) || state == T6;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = run ? T0 : IDLE;
      T0: nxt = T1;
      T1: nxt = w_mem_ready ? T2 : T1;
      T2: nxt = T3;
      T3: nxt = bad ? FAULT : T4;
      T4: nxt = T5;
      T5: nxt = muldiv ? T6 : (run ? T0 : IDLE);
`ifdef ALU_SEQ_MULDIV_EN
      T6: nxt = run ? T0 : IDLE;
`endif
      default: nxt = FAULT;
    endcase
  end
  always_ff @(posedge w_clock) begin
    if (w_clear) begin
      state <= IDLE;
      t1_first <= 1'b0;
      {op, ra, rb, rc} <= '0;
    end else begin
      state <= nxt;
      t1_first <= state == T0;
      if (state == T2) {op, ra, rb, rc} <= ir_in[IR_W-1 -: OP_W+3*RIDX_W];
    end
  end
  assign t3_drive = state == T3 && !unary && !bad;
  assign s_PC = state == T0;
  assign e_MAR = state == T0;
  assign w_IncPC = state == T0;
  assign e_PC = state == T1 && t1_first;
  assign w_read = state == T1;
  assign e_MDR = state == T1;
  assign s_MDR = state == T2;
  assign e_IR = state == T2;
  assign e_Y = t3_drive;
  assign e_alu = state == T4;
  assign e_Z = state == T0 || state == T4;
  assign s_Zlow = state == T1 || state == T5;
  assign e_LO = state == T5 && muldiv;
`ifdef ALU_SEQ_MULDIV_EN
  assign s_Zhigh = state == T6;
  assign e_HI = state == T6;
`else
  assign s_Zhigh = 1'b0;
  assign e_HI = 1'b0;
`endif
  assign s_R = t3_drive ? ONE << rb : state == T4 ? ONE << (unary ? rb : rc) : '0;
  assign e_R = state == T5 && !muldiv ? ONE << ra : '0;
  assign alu_opcode = state >= T3 && state <= T6 ? op : '0;
  assign busy = state != IDLE && state != FAULT;
  assign done = retire;
  assign illegal = state == FAULT;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench; per-cycle expected control snapshots are queued and popped each clock.
module tb_alu_sequencer;
  localparam logic [3:0] S_IDLE = 0, S_T0 = 1, S_T1 = 2, S_T2 = 3, S_T3 = 4, S_T4 = 5, S_T5 = 6, S_T6 = 7, S_FAULT = 8;
  localparam logic [14:0] C_SPC = 15'h4000, C_EMAR = 15'h2000, C_INC = 15'h1000, C_EPC = 15'h0800;
  localparam logic [14:0] C_RD = 15'h0400, C_EMDR = 15'h0200, C_SMDR = 15'h0100, C_EIR = 15'h0080;
  localparam logic [14:0] C_EY = 15'h0040, C_EALU = 15'h0020, C_EZ = 15'h0010, C_SZL = 15'h0008;
  localparam logic [14:0] C_SZH = 15'h0004, C_ELO = 15'h0002, C_EHI = 15'h0001;
  localparam int BIN = 0, UN = 1, MD = 2, ILL = 3;
  localparam logic [31:0] OR_I = 32'h18918000, NEG_I = 32'h62280000, MUL_I = 32'h2B3C0000, BAD_I = 32'h68000000;
  logic w_clock = 0, w_clear = 1, run = 0, w_mem_ready = 1;
  logic [31:0] ir_in = '0;
  logic s_PC, e_MAR, w_IncPC, e_PC, w_read, e_MDR, s_MDR, e_IR;
  logic e_Y, e_alu, e_Z, s_Zlow, s_Zhigh, e_LO, e_HI, busy, done, illegal;
  logic [4:0] alu_opcode;
  logic [15:0] s_R, e_R;
  logic [3:0] state;
  logic [14:0] ctrl;
  alu_sequencer dut (
    .w_clock(w_clock), .w_clear(w_clear), .run(run), .w_mem_ready(w_mem_ready), .ir_in(ir_in),
    .s_PC(s_PC), .e_MAR(e_MAR), .w_IncPC(w_IncPC), .e_PC(e_PC),
    .w_read(w_read), .e_MDR(e_MDR), .s_MDR(s_MDR), .e_IR(e_IR),
    .e_Y(e_Y), .e_alu(e_alu), .e_Z(e_Z), .s_Zlow(s_Zlow), .s_Zhigh(s_Zhigh), .e_LO(e_LO), .e_HI(e_HI),
    .alu_opcode(alu_opcode), .s_R(s_R), .e_R(e_R), .busy(busy), .done(done), .illegal(illegal), .state(state)
  );
  assign ctrl = {s_PC, e_MAR, w_IncPC, e_PC, w_read, e_MDR, s_MDR, e_IR, e_Y, e_alu, e_Z, s_Zlow, s_Zhigh, e_LO, e_HI};
  always #5 w_clock = ~w_clock;
  typedef struct {
    logic [3:0] st;
    logic [14:0] c;
    logic [15:0] sr;
    logic [15:0] er;
    logic [4:0] op;
    logic dn;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  string cur = "";
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s/%s: got %h expected %h", cur, tag, got, want);
    end
  endtask
  task automatic push(input logic [3:0] st, input logic [14:0] c, input logic [15:0] sr, input logic [15:0] er,
                      input logic [4:0] op, input logic dn);
    q.push_back('{st, c, sr, er, op, dn});
  endtask
  task automatic step(input logic r, input logic rdy);
    exp_t e;
    run = r;
    w_mem_ready = rdy;
    @(posedge w_clock);
    #1;
    check("queued", 32'(q.size() > 0), 1);
    if (q.size() > 0) begin
      e = q.pop_front();
      check("state", 32'(state), 32'(e.st));
      check("ctrl", 32'(ctrl), 32'(e.c));
      check("s_R", 32'(s_R), 32'(e.sr));
      check("e_R", 32'(e_R), 32'(e.er));
      check("alu_opcode", 32'(alu_opcode), 32'(e.op));
      check("done", 32'(done), 32'(e.dn));
      check("busy", 32'(busy), 32'(e.st != S_IDLE && e.st != S_FAULT));
      check("illegal", 32'(illegal), 32'(e.st == S_FAULT));
    end
  endtask
  task automatic push_fetch(input int waits);
    push(S_T0, C_SPC | C_EMAR | C_INC | C_EZ, 0, 0, 0, 0);
    push(S_T1, C_SZL | C_EPC | C_RD | C_EMDR, 0, 0, 0, 0);
    repeat (waits) push(S_T1, C_SZL | C_RD | C_EMDR, 0, 0, 0, 0);
    push(S_T2, C_SMDR | C_EIR, 0, 0, 0, 0);
  endtask
  task automatic push_body(input int kind, input logic [15:0] ra, input logic [15:0] rb, input logic [15:0] rc,
                           input logic [4:0] op);
    if (kind == BIN || kind == MD) begin
      push(S_T3, C_EY, rb, 0, op, 0);
      push(S_T4, C_EALU | C_EZ, rc, 0, op, 0);
    end else if (kind == UN) begin
      push(S_T3, 0, 0, 0, op, 0);
      push(S_T4, C_EALU | C_EZ, rb, 0, op, 0);
    end else begin
      push(S_T3, 0, 0, 0, op, 0);
      push(S_FAULT, 0, 0, 0, 0, 0);
    end
    if (kind == BIN || kind == UN) push(S_T5, C_SZL, 0, ra, op, 1);
    if (kind == MD) begin
      push(S_T5, C_SZL | C_ELO, 0, 0, op, 0);
      push(S_T6, C_SZH | C_EHI, 0, 0, op, 1);
    end
  endtask
  task automatic instr(input string name, input logic [31:0] ir, input int waits, input logic hold, input int kind,
                       input logic [15:0] ra, input logic [15:0] rb, input logic [15:0] rc, input logic [4:0] op);
    cur = name;
    ir_in = ir;
    push_fetch(waits);
    push_body(kind, ra, rb, rc, op);
    for (int k = 0; q.size() > 0 && k < 64; k++) step(k == 0 || hold, !(k >= 2 && k < 2 + waits));
  endtask
  task automatic idle_step();
    push(S_IDLE, 0, 0, 0, 0, 0);
    step(1'b0, 1'b1);
  endtask
  task automatic fault_hold_clear();
    repeat (2) begin
      push(S_FAULT, 0, 0, 0, 0, 0);
      step(1'b1, 1'b1);
    end
    w_clear = 1;
    push(S_IDLE, 0, 0, 0, 0, 0);
    step(1'b1, 1'b1);
    w_clear = 0;
    idle_step();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    cur = "reset";
    push(S_IDLE, 0, 0, 0, 0, 0);
    step(1'b1, 1'b1);
    w_clear = 0;
    idle_step();
    instr("or", OR_I, 0, 0, BIN, 16'h0002, 16'h0004, 16'h0008, 5'd3);
    idle_step();
    instr("neg", NEG_I, 0, 0, UN, 16'h0010, 16'h0020, 16'h0000, 5'd12);
    idle_step();
    instr("wait3", OR_I, 3, 0, BIN, 16'h0002, 16'h0004, 16'h0008, 5'd3);
    idle_step();
    instr("b2b_or", OR_I, 0, 1, BIN, 16'h0002, 16'h0004, 16'h0008, 5'd3);
    instr("b2b_neg", NEG_I, 1, 1, UN, 16'h0010, 16'h0020, 16'h0000, 5'd12);
    idle_step();
    cur = "clear_t4";
    ir_in = OR_I;
    push_fetch(0);
    push(S_T3, C_EY, 16'h0004, 0, 5'd3, 0);
    push(S_T4, C_EALU | C_EZ, 16'h0008, 0, 5'd3, 0);
    repeat (5) step(1'b1, 1'b1);
    w_clear = 1;
    push(S_IDLE, 0, 0, 0, 0, 0);
    step(1'b1, 1'b1);
    w_clear = 0;
    idle_step();
`ifdef ALU_SEQ_MULDIV_EN
    instr("mul", MUL_I, 0, 0, MD, 16'h0040, 16'h0080, 16'h0100, 5'd5);
    idle_step();
`else
    instr("mul_off", MUL_I, 0, 0, ILL, 16'h0040, 16'h0080, 16'h0100, 5'd5);
    fault_hold_clear();
`endif
    instr("illegal", BAD_I, 0, 0, ILL, 0, 0, 0, 5'd13);
    fault_hold_clear();
    instr("after_fault", OR_I, 0, 0, BIN, 16'h0002, 16'h0004, 16'h0008, 5'd3);
    idle_step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
